// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Opcode constants, NOP encoding and the fetch FSM states.
package riscv_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      FS_IDLE = 3'd0,
      FS_REQ  = 3'd1,
      FS_WAIT = 3'd2,
      FS_HOLD = 3'd3,
      FS_HALT = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-deep imem request, held
// instruction for decode, redirect handling and sticky fault.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_fault
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] pc_inc;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] ipc_q;
   logic            kill;
   logic            fault;
   logic            redir_ok;
   logic            redir_bad;

   // Redirect qualification and sequential PC.
   always_comb begin
      redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
      redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
      pc_inc    = pc + XLEN'(4);
   end

   // Fetch FSM; req_addr only moves when a new request starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FS_IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         instr_q  <= INSTR_NOP;
         ipc_q    <= RESET_PC;
         kill     <= 1'b0;
         fault    <= 1'b0;
      end else if (state != FS_HALT && redir_bad) begin
         state <= FS_HALT;
         fault <= 1'b1;
         kill  <= 1'b0;
      end else begin
         unique case (state)
            FS_IDLE: begin
               state <= FS_REQ;
               if (redir_ok) begin
                  pc       <= redirect_pc;
                  req_addr <= redirect_pc;
               end
            end
            FS_REQ: begin
               if (redir_ok) begin
                  pc   <= redirect_pc;
                  kill <= 1'b1;
               end
               if (imem_req_ready) state <= FS_WAIT;
            end
            FS_WAIT: begin
               if (imem_rsp_valid) begin
                  kill  <= 1'b0;
                  state <= FS_REQ;
                  if (redir_ok) begin
                     pc       <= redirect_pc;
                     req_addr <= redirect_pc;
                  end else if (kill) begin
                     req_addr <= pc;
                  end else begin
                     instr_q <= imem_rsp_data;
                     ipc_q   <= pc;
                     state   <= FS_HOLD;
                  end
               end else if (redir_ok) begin
                  pc   <= redirect_pc;
                  kill <= 1'b1;
               end
            end
            FS_HOLD: begin
               if (redir_ok) begin
                  pc       <= redirect_pc;
                  req_addr <= redirect_pc;
                  state    <= FS_REQ;
               end else if (instr_ready) begin
                  pc       <= pc_inc;
                  req_addr <= pc_inc;
                  state    <= FS_REQ;
               end
            end
            FS_HALT: begin
               state <= FS_HALT;
            end
            default: begin
               state <= FS_IDLE;
            end
         endcase
      end
   end

   // Outputs come from registers or state decode only.
   always_comb begin
      imem_req_valid = (state == FS_REQ);
      imem_req_addr  = req_addr;
      instr_valid    = (state == FS_HOLD);
      instr          = instr_q;
      instr_pc       = ipc_q;
      opcode         = instr_q[6:0];
      fetch_fault    = fault;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with request/instruction
// scoreboards, opcode table, and redirect/fault/reset sequences.
module tb_instr_fetch;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   logic        w_req_valid;
   logic [31:0] w_req_addr;
   logic        w_instr_valid;
   logic [31:0] w_instr;
   logic [31:0] w_instr_pc;
   logic [6:0]  w_opcode;
   logic        w_fault;

   always #5 clk = ~clk;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc),
      .opcode(opcode),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .fetch_fault(fetch_fault)
   );

   instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(w_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(w_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .instr_valid(w_instr_valid),
      .instr_ready(instr_ready),
      .instr(w_instr), .instr_pc(w_instr_pc),
      .opcode(w_opcode),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .fetch_fault(w_fault)
   );

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic [6:0]  opc;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        iq[$];
   logic [31:0] aq[$];
   bit          outst;
   int          cnt;
   logic [31:0] out_addr;
   bit          tb_kill;
   bit          tb_halt;
   logic [31:0] mem_word;
   int          rsp_lat;
   logic [31:0] pcv;
   vec_t        tab[6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // One clock: score the current cycle, step, update memory.
   task automatic tick();
      exp_t e;
      if (instr_valid && (instr_ready || redirect_valid)) begin
         if (iq.size() == 0) begin
            chk("instr_unexpected", 32'(instr_valid), 32'h0);
         end else begin
            e = iq.pop_front();
            chk("sb_instr", instr, e.data);
            chk("sb_instr_pc", instr_pc, e.pc);
            chk("sb_opcode", 32'(opcode), 32'(e.data[6:0]));
         end
      end
      if (redirect_valid && redirect_pc[1:0] != 2'b00) tb_halt = 1;
      if (imem_rsp_valid) begin
         if (tb_kill || redirect_valid || tb_halt) tb_kill = 0;
         else iq.push_back('{imem_rsp_data, out_addr});
      end else if (redirect_valid && !tb_halt &&
                   (outst || imem_req_valid)) begin
         tb_kill = 1;
      end
      if (imem_req_valid && imem_req_ready) begin
         if (aq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_unexpected: got request at %h required none",
                     imem_req_addr);
         end else begin
            chk("sb_req_addr", imem_req_addr, aq.pop_front());
         end
         outst    = 1;
         cnt      = rsp_lat;
         out_addr = imem_req_addr;
      end
      @(posedge clk);
      @(negedge clk);
      imem_rsp_valid = 0;
      if (outst) begin
         cnt--;
         if (cnt == 0) begin
            outst          = 0;
            imem_rsp_valid = 1;
            imem_rsp_data  = mem_word;
         end
      end
   endtask

   task automatic wait_hold(input string nm);
      int k = 0;
      while (!instr_valid && k < 20) begin
         tick();
         k++;
      end
      chk({nm, "_hold"}, 32'(instr_valid), 32'h1);
   endtask

   // Reset DUT and memory model; check reset values mid-reset.
   task automatic do_reset();
      rst_n          = 0;
      imem_rsp_valid = 0;
      redirect_valid = 0;
      outst          = 0;
      tb_kill        = 0;
      tb_halt        = 0;
      iq.delete();
      aq.delete();
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_opcode", 32'(opcode), 32'h13);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'h0);
      chk("rst_w_addr", w_req_addr, 32'hFFFF_FFFC);
      chk("rst_w_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
      rst_n = 1;
   endtask

   initial begin
      tab[0] = '{32'h00A0_0093, 7'b0010011};
      tab[1] = '{32'h0020_81B3, 7'b0110011};
      tab[2] = '{32'h0000_A103, 7'b0000011};
      tab[3] = '{32'h0020_A023, 7'b0100011};
      tab[4] = '{32'h0020_8463, 7'b1100011};
      tab[5] = '{32'hFFFF_FFFF, 7'b1111111};

      imem_req_ready = 1;
      instr_ready    = 1;
      redirect_valid = 0;
      redirect_pc    = 0;
      imem_rsp_data  = 0;
      mem_word       = 32'h00A0_0093;
      rsp_lat        = 1;
      do_reset();

      aq.push_back(32'h0);
      aq.push_back(32'h4);
      chk("c0_req_valid", 32'(imem_req_valid), 32'h0);
      tick();
      chk("c1_req_valid", 32'(imem_req_valid), 32'h1);
      chk("c1_req_addr", imem_req_addr, 32'h0);
      chk("c1_w_addr", w_req_addr, 32'hFFFF_FFFC);
      tick();
      chk("c2_instr_valid", 32'(instr_valid), 32'h0);
      tick();
      chk("c3_instr_valid", 32'(instr_valid), 32'h1);
      chk("c3_opcode", 32'(opcode), 32'h13);
      chk("c3_instr_pc", instr_pc, 32'h0);
      chk("c3_w_instr", w_instr, 32'h00A0_0093);
      chk("c3_w_opcode", 32'(w_opcode), 32'h13);
      chk("c3_w_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
      chk("c3_w_valid", 32'(w_instr_valid), 32'h1);
      tick();
      chk("wrap_w_addr", w_req_addr, 32'h0);
      chk("wrap_w_valid", 32'(w_req_valid), 32'h1);
      chk("c4_req_addr", imem_req_addr, 32'h4);

      instr_ready = 0;
      wait_hold("bp");
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(instr_valid), 32'h1);
         chk("bp_no_req", 32'(imem_req_valid), 32'h0);
         chk("bp_instr", instr, 32'h00A0_0093);
         chk("bp_pc", instr_pc, 32'h4);
         tick();
      end
      aq.push_back(32'h8);
      instr_ready = 1;
      tick();
      chk("bp_next_addr", imem_req_addr, 32'h8);

      rsp_lat = 2;
      tick();
      aq.push_back(32'h100);
      redirect_valid = 1;
      redirect_pc    = 32'h100;
      tick();
      redirect_valid = 0;
      rsp_lat        = 1;
      mem_word       = 32'h0020_81B3;
      tick();
      chk("rw_req_valid", 32'(imem_req_valid), 32'h1);
      chk("rw_req_addr", imem_req_addr, 32'h100);
      instr_ready = 0;
      wait_hold("rw");
      chk("rw_instr_pc", instr_pc, 32'h100);

      aq.push_back(32'h40);
      instr_ready    = 1;
      redirect_valid = 1;
      redirect_pc    = 32'h40;
      tick();
      redirect_valid = 0;
      chk("rh_req_valid", 32'(imem_req_valid), 32'h1);
      chk("rh_req_addr", imem_req_addr, 32'h40);

      pcv = 32'h40;
      foreach (tab[i]) begin
         mem_word    = tab[i].data;
         instr_ready = 0;
         wait_hold("tab");
         chk("tab_instr", instr, tab[i].data);
         chk("tab_opcode", 32'(opcode), 32'(tab[i].opc));
         chk("tab_pc", instr_pc, pcv);
         pcv = pcv + 4;
         aq.push_back(pcv);
         instr_ready = 1;
         tick();
      end

      imem_req_ready = 0;
      redirect_valid = 1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 0;
      chk("rq_req_valid", 32'(imem_req_valid), 32'h1);
      chk("rq_addr_hold", imem_req_addr, 32'h58);
      tick();
      chk("rq_addr_hold2", imem_req_addr, 32'h58);
      aq.push_back(32'h200);
      imem_req_ready = 1;
      tick();
      tick();
      chk("rq_new_addr", imem_req_addr, 32'h200);
      instr_ready = 0;
      wait_hold("rq");
      chk("rq_instr_pc", instr_pc, 32'h200);
      chk("iq_drained", 32'(iq.size()), 32'h1);

      aq.push_back(32'h204);
      instr_ready = 1;
      tick();
      rsp_lat = 2;
      tick();
      redirect_valid = 1;
      redirect_pc    = 32'h102;
      tick();
      redirect_valid = 0;
      for (int i = 0; i < 4; i++) begin
         chk("mis_fault", 32'(fetch_fault), 32'h1);
         chk("mis_no_req", 32'(imem_req_valid), 32'h0);
         chk("mis_no_instr", 32'(instr_valid), 32'h0);
         tick();
      end
      rsp_lat = 1;
      do_reset();
      aq.push_back(32'h0);
      tick();
      chk("restart_valid", 32'(imem_req_valid), 32'h1);
      chk("restart_addr", imem_req_addr, 32'h0);

      imem_req_ready = 0;
      #2;
      rst_n = 0;
      #1;
      chk("async_rst_valid", 32'(imem_req_valid), 32'h0);
      chk("async_rst_w", 32'(w_req_valid), 32'h0);
      @(negedge clk);
      rst_n = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no end of test required finish");
      $fatal(1, "timeout");
   end

endmodule
